// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple processor and its memory-side blocks.
package simple_processor_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;

    // Data-memory controller defaults.
    localparam int unsigned DMEM_DEPTH = 1024;
    localparam int unsigned DMEM_WAIT  = 0;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        WAIT,
        RESP
    } dmem_ctrl_state_e;

    // Width of a down-counter that must hold n; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory controller: latches one processor request, drives a single-port
// synchronous SRAM with optional wait states, and returns a one-cycle ack with
// registered read data or an error response for misaligned/out-of-range accesses.
module dmem_ctrl #(
    parameter int unsigned ADDR_WIDTH  = simple_processor_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = simple_processor_pkg::DATA_WIDTH,
    parameter int unsigned MEM_DEPTH   = simple_processor_pkg::DMEM_DEPTH,
    parameter int unsigned WAIT_CYCLES = simple_processor_pkg::DMEM_WAIT
) (
    input  logic                         clk_i,
    input  logic                         arst_ni,
    input  logic                         req_i,
    input  logic                         we_i,
    input  logic [ADDR_WIDTH-1:0]        addr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic                         ack_o,
    output logic                         err_o,
    output logic                         busy_o,
    output logic                         mem_cs_o,
    output logic                         mem_we_o,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]        mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]        mem_rdata_i
);

    import simple_processor_pkg::*;

    localparam int unsigned OFS   = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);

    // Byte-offset bits inside one data word; all zero when DATA_WIDTH is 8.
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'((64'd1 << OFS) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

    dmem_ctrl_state_e state_q, state_d;

    logic                  we_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_hold_q;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  req_err;

    // Request decode: word index, plus rejection of misaligned or out-of-range addresses.
    assign word_idx = addr_i >> OFS;
    assign req_err  = (|(addr_i & OFS_MASK)) || (word_idx >= DEPTH_A);

    // State register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; errors skip the SRAM entirely and go straight to RESP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
            WAIT: begin
                // Counter is loaded with WAIT_CYCLES, so leaving at 1 gives exactly that many.
                if (cnt_q <= CNT_ONE) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latches, wait counter and read-data registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            rdata_hold_q <= '0;
        end else begin
            if ((state_q == IDLE) && req_i) begin
                we_q    <= we_i;
                idx_q   <= word_idx[IDX_W-1:0];
                wdata_q <= wdata_i;
                err_q   <= req_err;
                // A rejected access reports zero data and leaves zero behind.
                if (req_err) begin
                    rdata_q <= '0;
                end
            end
            if (state_q == ACCESS) begin
                cnt_q <= CNT_LOAD;
            end
            if (state_q == WAIT) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
            if ((state_q == CAPTURE) && !we_q) begin
                rdata_q <= mem_rdata_i;
            end
            if (state_q == RESP) begin
                rdata_hold_q <= rdata_q;
            end
        end
    end

    // Outputs: SRAM strobes only in ACCESS, response only in RESP.
    always_comb begin
        mem_cs_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        ack_o       = 1'b0;
        err_o       = 1'b0;
        if (state_q == ACCESS) begin
            mem_cs_o    = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = idx_q;
            mem_wdata_o = wdata_q;
        end
        if (state_q == RESP) begin
            ack_o = 1'b1;
            err_o = err_q;
        end
    end

    // rdata_o only changes at the start of RESP and holds between transactions.
    assign rdata_o = (state_q == RESP) ? rdata_q : rdata_hold_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (0, 2 and 3 wait states), each on its own
// behavioural SRAM, driven with directed transactions and hand-computed expectations.

// Behavioural single-port SRAM, 1-cycle read latency, with a preload port.
module sp_sram #(
    parameter int unsigned Depth = 1024,
    parameter int unsigned Width = 32
) (
    input  logic                     clk_i,
    input  logic                     cs_i,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] addr_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    input  logic                     pl_en_i,
    input  logic [$clog2(Depth)-1:0] pl_addr_i,
    input  logic [Width-1:0]         pl_data_i
);
    logic [Width-1:0] mem [Depth];

    always @(posedge clk_i) begin
        if (pl_en_i) mem[pl_addr_i] <= pl_data_i;
        if (cs_i) begin
            if (we_i) mem[addr_i] <= wdata_i;
            else      rdata_o     <= mem[addr_i];
        end
    end
endmodule

module tb_dmem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n;
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ack   [3];
    logic        err   [3];
    logic        busy  [3];
    logic        cs    [3];
    logic        mwe   [3];
    logic [9:0]  maddr [3];
    logic [31:0] mwdata[3];
    logic [31:0] mrdata[3];
    logic        pl_en  [3];
    logic [9:0]  pl_addr[3];
    logic [31:0] pl_data[3];

    int ack_cnt[3];
    int cs_cnt [3];
    int wr_cnt [3];
    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        dmem_ctrl #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .MEM_DEPTH  (1024),
            .WAIT_CYCLES(W)
        ) u_dut (
            .clk_i      (clk),
            .arst_ni    (arst_n),
            .req_i      (req[g]),
            .we_i       (we[g]),
            .addr_i     (addr[g]),
            .wdata_i    (wdata[g]),
            .rdata_o    (rdata[g]),
            .ack_o      (ack[g]),
            .err_o      (err[g]),
            .busy_o     (busy[g]),
            .mem_cs_o   (cs[g]),
            .mem_we_o   (mwe[g]),
            .mem_addr_o (maddr[g]),
            .mem_wdata_o(mwdata[g]),
            .mem_rdata_i(mrdata[g])
        );
        sp_sram #(
            .Depth(1024),
            .Width(32)
        ) u_sram (
            .clk_i    (clk),
            .cs_i     (cs[g]),
            .we_i     (mwe[g]),
            .addr_i   (maddr[g]),
            .wdata_i  (mwdata[g]),
            .rdata_o  (mrdata[g]),
            .pl_en_i  (pl_en[g]),
            .pl_addr_i(pl_addr[g]),
            .pl_data_i(pl_data[g])
        );
    end

    // Event counters sampled on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ack[i])            ack_cnt[i]++;
            if (cs[i])             cs_cnt[i]++;
            if (cs[i] && mwe[i])   wr_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int d, input logic [9:0] a, input logic [31:0] v);
        @(negedge clk);
        pl_en[d]   = 1'b1;
        pl_addr[d] = a;
        pl_data[d] = v;
        @(negedge clk);
        pl_en[d]   = 1'b0;
    endtask

    // One-cycle request pulse; returns cycles to ack plus the SRAM strobe seen right after.
    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic e, output logic [31:0] rd,
                       output logic c1, output logic [9:0] a1);
        @(negedge clk);
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        @(negedge clk);
        c1     = cs[d];
        a1     = maddr[d];
        req[d] = 1'b0;
        lat    = 1;
        while (!ack[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e  = err[d];
        rd = rdata[d];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        e;
        logic [31:0] rd;
        logic        c1;
        logic [9:0]  a1;
        int          c0, w0, a0, last;

        for (int i = 0; i < 3; i++) begin
            req[i] = 0; we[i] = 0; addr[i] = '0; wdata[i] = '0;
            pl_en[i] = 0; pl_addr[i] = '0; pl_data[i] = '0;
        end
        arst_n = 1'b1;
        #1 arst_n = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            check("rst_rdata", rdata[i], 32'h0);
            check("rst_ack",   {31'b0, ack[i]}, 32'h0);
            check("rst_err",   {31'b0, err[i]}, 32'h0);
            check("rst_busy",  {31'b0, busy[i]}, 32'h0);
            check("rst_mem",   {mwdata[i][20:0], cs[i], mwe[i], maddr[i]}, 32'h0);
        end
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;

        // Read on zero-wait instance.
        preload(0, 10'd5, 32'hDEADBEEF);
        preload(0, 10'd0, 32'h0BADF00D);
        txn(0, 1'b0, 32'h14, 32'h0, lat, e, rd, c1, a1);
        check("rd_lat",  lat, 3);
        check("rd_err",  {31'b0, e}, 32'h0);
        check("rd_data", rd, 32'hDEADBEEF);
        check("rd_cs",   {31'b0, c1}, 32'h1);
        check("rd_addr", {22'b0, a1}, 32'd5);
        @(negedge clk);
        check("rd_hold", rdata[0], 32'hDEADBEEF);
        check("rd_idle", {31'b0, busy[0]}, 32'h0);

        // Error responses never touch the SRAM.
        c0 = cs_cnt[0];
        txn(0, 1'b0, 32'h1002, 32'h0, lat, e, rd, c1, a1);
        check("err_mis_lat",  lat, 1);
        check("err_mis_err",  {31'b0, e}, 32'h1);
        check("err_mis_data", rd, 32'h0);
        check("err_mis_cs",   {31'b0, c1}, 32'h0);
        txn(0, 1'b1, 32'h1000, 32'hFFFFFFFF, lat, e, rd, c1, a1);
        check("err_oor_lat",  lat, 1);
        check("err_oor_err",  {31'b0, e}, 32'h1);
        check("err_oor_data", rd, 32'h0);
        txn(0, 1'b0, 32'h16, 32'h0, lat, e, rd, c1, a1);
        check("err_half_err", {31'b0, e}, 32'h1);
        @(negedge clk);
        check("err_hold",   rdata[0], 32'h0);
        check("err_no_cs",  cs_cnt[0] - c0, 0);

        // Write then read-back with two wait states.
        preload(1, 10'd3, 32'hA5A5A5A5);
        txn(1, 1'b0, 32'hC, 32'h0, lat, e, rd, c1, a1);
        check("w2_pre_data", rd, 32'hA5A5A5A5);
        txn(1, 1'b1, 32'h40, 32'h12345678, lat, e, rd, c1, a1);
        check("w2_wr_lat",  lat, 5);
        check("w2_wr_err",  {31'b0, e}, 32'h0);
        check("w2_wr_data", rd, 32'hA5A5A5A5);
        check("w2_wr_addr", {22'b0, a1}, 32'd16);
        txn(1, 1'b0, 32'h40, 32'h0, lat, e, rd, c1, a1);
        check("w2_rd_lat",  lat, 5);
        check("w2_rd_data", rd, 32'h12345678);

        // Back-to-back: req held high for 20 cycles.
        a0 = ack_cnt[0];
        c0 = cs_cnt[0];
        last = -1;
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack[0]) begin
                if (last < 0) check("b2b_first", k, 3);
                else          check("b2b_gap", k - last, 4);
                check("b2b_data", rdata[0], 32'h0BADF00D);
                last = k;
            end
        end
        req[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("b2b_acks", ack_cnt[0] - a0, 5);
        check("b2b_cs",   cs_cnt[0] - c0, 5);

        // Abort immunity: one-cycle write pulse still completes once.
        w0 = wr_cnt[0];
        a0 = ack_cnt[0];
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'hCAFEF00D;
        @(negedge clk);
        req[0] = 1'b0; we[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_wr",  wr_cnt[0] - w0, 1);
        check("abort_ack", ack_cnt[0] - a0, 1);
        txn(0, 1'b0, 32'h8, 32'h0, lat, e, rd, c1, a1);
        check("abort_data", rd, 32'hCAFEF00D);

        // Reset during WAIT on the three-wait-state instance.
        preload(2, 10'd8, 32'h11111111);
        txn(2, 1'b0, 32'h20, 32'h0, lat, e, rd, c1, a1);
        check("w3_rd_lat",  lat, 6);
        check("w3_rd_data", rd, 32'h11111111);
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h24; wdata[2] = 32'h55AA55AA;
        @(negedge clk);
        req[2] = 1'b0; we[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", {31'b0, busy[2]}, 32'h1);
        w0 = wr_cnt[2];
        a0 = ack_cnt[2];
        #1 arst_n = 1'b0;
        #1;
        check("mid_rst_busy",  {31'b0, busy[2]}, 32'h0);
        check("mid_rst_rdata", rdata[2], 32'h0);
        check("mid_rst_out",   {ack[2], err[2], cs[2], mwe[2], maddr[2]}, 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_post_busy", {31'b0, busy[2]}, 32'h0);
        check("mid_post_ack",  ack_cnt[2] - a0, 0);
        check("mid_post_wr",   wr_cnt[2] - w0, 0);
        txn(2, 1'b0, 32'h20, 32'h0, lat, e, rd, c1, a1);
        check("mid_again_lat",  lat, 6);
        check("mid_again_data", rd, 32'h11111111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
